dm_cache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate cache controller between the requesting processor/testbench and the `mainMem` main-memory model. Read hits return in one cycle. Read misses and all writes go to main memory through its enable/requestComplete handshake, which has a multi-cycle delay. The block also keeps saturating hit/miss counters for the cache-performance measurements in this lab.

---
 rtl/dm_cache_ctrl_pkg.sv | 20 ++
 rtl/dm_cache_ctrl_line_array.sv | 47 ++++
 rtl/dm_cache_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types and geometry helpers for the direct-mapped cache controller.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_START = 2'd1,
        MEM_WAIT  = 2'd2,
        RESP      = 2'd3
    } cache_state_t;

    function automatic int unsigned idx_width(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_width,
                                              input int unsigned num_lines);
        return addr_width - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_line_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write
// port, synchronous clear of every valid bit.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned IDX_W      = idx_width(NUM_LINES),
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_clr,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic                  o_rd_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [DATA_WIDTH-1:0] i_wr_data
);

    logic [NUM_LINES-1:0]  r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_LINES];
    logic [DATA_WIDTH-1:0] r_data [NUM_LINES];

    // Clear wins over a same-cycle write so an abandoned fill never survives.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// saturating hit/miss statistics.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_hit,
    output logic                  mem_enable,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_complete,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int unsigned IDX_W = idx_width(NUM_LINES);
    localparam int unsigned TAG_W = tag_width(ADDR_WIDTH, NUM_LINES);

    cache_state_t r_state;
    cache_state_t w_next;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_hit;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    logic                  w_clr;
    logic                  w_accept;
    logic                  w_lookup_hit;
    logic                  w_fill;
    logic [IDX_W-1:0]      w_req_idx;
    logic [TAG_W-1:0]      w_req_tag;
    logic                  w_line_valid;
    logic [TAG_W-1:0]      w_line_tag;
    logic [DATA_WIDTH-1:0] w_line_data;
    logic                  w_arr_we;
    logic [IDX_W-1:0]      w_arr_widx;
    logic [TAG_W-1:0]      w_arr_wtag;
    logic [DATA_WIDTH-1:0] w_arr_wdata;

    assign w_clr        = !reset_n;
    assign w_req_idx    = req_addr[IDX_W-1:0];
    assign w_req_tag    = req_addr[ADDR_WIDTH-1:IDX_W];
    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_lookup_hit = w_line_valid && (w_line_tag == w_req_tag);
    assign w_fill       = (r_state == MEM_WAIT) && mem_complete && !r_we;

    cache_line_array #(
        .NUM_LINES  (NUM_LINES),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lines (
        .clk        (clk),
        .i_clr      (w_clr),
        .i_rd_idx   (w_req_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_arr_we),
        .i_wr_idx   (w_arr_widx),
        .i_wr_tag   (w_arr_wtag),
        .i_wr_data  (w_arr_wdata)
    );

    // Fills (MEM_WAIT) and write-hit updates (IDLE) can never coincide.
    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_widx  = w_req_idx;
        w_arr_wtag  = w_req_tag;
        w_arr_wdata = req_wdata;
        if (!reset_n) begin
            w_arr_we = 1'b0;
        end else if (w_fill) begin
            w_arr_we    = 1'b1;
            w_arr_widx  = r_addr[IDX_W-1:0];
            w_arr_wtag  = r_addr[ADDR_WIDTH-1:IDX_W];
            w_arr_wdata = mem_rdata;
        end else if (w_accept && req_we && w_lookup_hit) begin
            w_arr_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // MEM_START never looks at mem_complete: it still reflects the last request.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next = (!req_we && w_lookup_hit) ? RESP : MEM_START;
                end
            end
            MEM_START: w_next = MEM_WAIT;
            MEM_WAIT: begin
                if (mem_complete) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_hit      <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_hit   <= w_lookup_hit;
                r_rdata <= req_we ? req_wdata : w_line_data;
                if (w_lookup_hit) begin
                    if (r_hit_cnt != '1) begin
                        r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
                    end
                end else if (r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
                end
            end
            if (w_fill) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_hit   = r_hit;
    assign mem_enable = (r_state == MEM_START) || (r_state == MEM_WAIT);
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl with a behavioural main memory and a
// word-level cache/memory reference model.
module tb_dm_cache_ctrl;

    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 32;
    localparam int unsigned NL   = 16;
    localparam int unsigned CW   = 3;
    localparam int          CMAX = (1 << CW) - 1;
    localparam int unsigned MEMN = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_hit;
    logic          mem_enable;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_complete;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int checks = 0;
    int errors = 0;

    dm_cache_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_LINES  (NL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_hit     (resp_hit),
        .mem_enable   (mem_enable),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_complete (mem_complete),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    // Main memory: a rising enable starts an access that completes mem_delay+1
    // edges later; requestComplete then stays high until the next rising enable.
    logic [DW-1:0] mem [MEMN];
    logic          mem_init = 1'b1;
    int            mem_delay = 0;
    logic          prev_en = 1'b0;
    logic          mem_busy = 1'b0;
    int            mem_cnt = 0;
    logic [AW-1:0] lat_addr;
    logic          lat_we;
    logic [DW-1:0] lat_wdata;

    initial begin
        mem_complete = 1'b0;
        mem_rdata    = '0;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(MEMN); i++) mem[i] <= DW'(i);
        end
        prev_en <= mem_enable;
        if (mem_enable && !prev_en) begin
            mem_complete <= 1'b0;
            mem_busy     <= 1'b1;
            mem_cnt      <= mem_delay;
            lat_addr     <= mem_addr;
            lat_we       <= mem_we;
            lat_wdata    <= mem_wdata;
        end else if (mem_busy) begin
            if (mem_cnt == 0) begin
                if (lat_we) mem[lat_addr] <= lat_wdata;
                else        mem_rdata     <= mem[lat_addr];
                mem_complete <= 1'b1;
                mem_busy     <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    // Reference model: each line remembers which word address it holds; the
    // data of any word is simply the current memory image (write-through).
    bit            m_valid [NL];
    int unsigned   m_addr  [NL];
    logic [DW-1:0] ref_mem [MEMN];
    int            m_hc;
    int            m_mc;

    task automatic model_reset();
        for (int i = 0; i < int'(NL); i++) m_valid[i] = 1'b0;
        m_hc = 0;
        m_mc = 0;
    endtask

    task automatic model_access(input logic we, input int unsigned addr, input logic [DW-1:0] wdata,
                                output logic hit, output logic [DW-1:0] data);
        int unsigned line;
        line = addr % NL;
        hit  = m_valid[line] && (m_addr[line] == addr);
        if (hit) begin
            if (m_hc < CMAX) m_hc++;
        end else if (m_mc < CMAX) begin
            m_mc++;
        end
        if (we) begin
            data          = wdata;
            ref_mem[addr] = wdata;
        end else begin
            data = ref_mem[addr];
            if (!hit) begin
                m_valid[line] = 1'b1;
                m_addr[line]  = addr;
            end
        end
    endtask

    typedef struct {
        logic          rdy_before;
        logic          en_first;
        logic          mem_bad;
        logic          timeout;
        logic          en_in_resp;
        logic          rdy_in_resp;
        logic          rdy_after;
        logic          rv_after;
        int            lat;
        logic [DW-1:0] rdata;
        logic          hit;
        logic [CW-1:0] hc;
        logic [CW-1:0] mc;
    } obs_t;

    // Drives one request from an idle negedge and records what the DUT did.
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          output obs_t o);
        o = '{default: 0};
        o.rdy_before = req_ready;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        o.en_first = mem_enable;
        o.lat      = 1;
        while (!resp_valid && o.lat < 200) begin
            if (mem_enable && (mem_addr !== addr || mem_we !== we || mem_wdata !== wdata))
                o.mem_bad = 1'b1;
            @(negedge clk);
            o.lat++;
        end
        o.timeout     = !resp_valid;
        o.rdata       = resp_rdata;
        o.hit         = resp_hit;
        o.hc          = hit_count;
        o.mc          = miss_count;
        o.en_in_resp  = mem_enable;
        o.rdy_in_resp = req_ready;
        @(negedge clk);
        o.rdy_after = req_ready;
        o.rv_after  = resp_valid;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_hit, mem_enable, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 0000", {resp_valid, resp_hit, mem_enable, mem_we});
        end
        checks++;
        if (resp_rdata !== '0 || mem_wdata !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_data: got rdata=%h wdata=%h addr=%h, expected all 0", resp_rdata, mem_wdata, mem_addr);
        end
        checks++;
        if (hit_count !== '0 || miss_count !== '0) begin
            errors++;
            $display("FAIL reset_counts: got %0d/%0d, expected 0/0", hit_count, miss_count);
        end
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 1", req_ready);
        end
    endtask

    task automatic test_directed();
        logic          t_we   [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        int unsigned   t_addr [10] = '{10, 10, 5, 21, 5, 50, 50, 50, 100, 100};
        logic [DW-1:0] t_wd   [10] = '{0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 32'h1234, 0};
        logic          t_hit  [10] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        logic [DW-1:0] t_data [10] = '{10, 10, 5, 21, 5, 50, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234, 32'h1234};
        for (int i = 0; i < 10; i++) begin
            obs_t          o;
            logic          mh;
            logic [DW-1:0] md;
            int            elat;
            mem_delay = $urandom_range(0, 4);
            model_access(t_we[i], t_addr[i], t_wd[i], mh, md);
            do_req(t_we[i], AW'(t_addr[i]), t_wd[i], o);
            elat = (t_hit[i] && !t_we[i]) ? 1 : mem_delay + 4;
            checks++;
            if (o.timeout !== 1'b0 || o.hit !== t_hit[i] || o.rdata !== t_data[i]) begin
                errors++;
                $display("FAIL dir_resp[%0d]: got to=%b hit=%b data=%h, expected to=0 hit=%b data=%h",
                         i, o.timeout, o.hit, o.rdata, t_hit[i], t_data[i]);
            end
            checks++;
            if (o.lat != elat) begin
                errors++;
                $display("FAIL dir_latency[%0d]: got %0d, expected %0d", i, o.lat, elat);
            end
            checks++;
            if (o.hc !== CW'(m_hc) || o.mc !== CW'(m_mc)) begin
                errors++;
                $display("FAIL dir_counts[%0d]: got %0d/%0d, expected %0d/%0d", i, o.hc, o.mc, m_hc, m_mc);
            end
            checks++;
            if ({o.rdy_before, o.en_first, o.mem_bad, o.en_in_resp, o.rdy_in_resp, o.rdy_after, o.rv_after}
                !== {1'b1, !(t_hit[i] && !t_we[i]), 5'b00010}) begin
                errors++;
                $display("FAIL dir_proto[%0d]: got %b, expected %b", i,
                         {o.rdy_before, o.en_first, o.mem_bad, o.en_in_resp, o.rdy_in_resp, o.rdy_after, o.rv_after},
                         {1'b1, !(t_hit[i] && !t_we[i]), 5'b00010});
            end
            if (t_we[i]) begin
                checks++;
                if (mem[t_addr[i]] !== t_wd[i]) begin
                    errors++;
                    $display("FAIL dir_memwrite[%0d]: got %h, expected %h", i, mem[t_addr[i]], t_wd[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic          mh;
        logic [DW-1:0] md;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = AW'(10);
        req_wdata = '0;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp_pat;
            exp_pat = (k % 2 == 0) ? 2'b10 : 2'b01;
            if (k % 2 == 0) model_access(1'b0, 10, '0, mh, md);
            checks++;
            if ({req_ready, resp_valid} !== exp_pat) begin
                errors++;
                $display("FAIL b2b_pattern[%0d]: got %b, expected %b", k, {req_ready, resp_valid}, exp_pat);
            end
            if (resp_valid) begin
                checks++;
                if (resp_hit !== 1'b1 || resp_rdata !== DW'(10)) begin
                    errors++;
                    $display("FAIL b2b_resp[%0d]: got hit=%b data=%h, expected hit=1 data=a", k, resp_hit, resp_rdata);
                end
            end
            if (k == 7) req_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (hit_count !== CW'(m_hc) || m_hc != CMAX) begin
            errors++;
            $display("FAIL b2b_saturate: got %0d, expected %0d (model %0d)", hit_count, CMAX, m_hc);
        end
    endtask

    task automatic test_reset_mid_miss();
        obs_t          o;
        logic          mh;
        logic [DW-1:0] md;
        logic          spurious;
        mem_delay = 30;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = AW'(200);
        req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_enable !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midmiss_wait: got en=%b rv=%b, expected en=1 rv=0", mem_enable, resp_valid);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_enable, resp_valid, resp_hit, mem_we} !== 4'b0000 || hit_count !== '0 || miss_count !== '0
            || mem_addr !== '0 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL midmiss_reset: got en=%b rv=%b cnt=%0d/%0d addr=%h, expected all 0",
                     mem_enable, resp_valid, hit_count, miss_count, mem_addr);
        end
        reset_n = 1'b1;
        model_reset();
        spurious = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_enable !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            errors++;
            $display("FAIL midmiss_quiet: got activity=%b, expected 0", spurious);
        end
        mem_delay = $urandom_range(0, 4);
        model_access(1'b0, 200, '0, mh, md);
        do_req(1'b0, AW'(200), '0, o);
        checks++;
        if (o.timeout !== 1'b0 || o.hit !== 1'b0 || o.rdata !== DW'(200) || o.mc !== 3'd1 || o.hc !== 3'd0) begin
            errors++;
            $display("FAIL midmiss_reread: got to=%b hit=%b data=%h cnt=%0d/%0d, expected to=0 hit=0 data=c8 cnt=0/1",
                     o.timeout, o.hit, o.rdata, o.hc, o.mc);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 250; n++) begin
            obs_t          o;
            logic          we;
            int unsigned   a;
            logic [DW-1:0] wd;
            logic          eh;
            logic [DW-1:0] ed;
            int            elat;
            we = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, MEMN - 1) : $urandom_range(0, 39);
            wd = $urandom;
            mem_delay = $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            model_access(we, a, wd, eh, ed);
            do_req(we, AW'(a), wd, o);
            elat = (eh && !we) ? 1 : mem_delay + 4;
            checks++;
            if (o.timeout !== 1'b0 || o.hit !== eh || o.rdata !== ed) begin
                errors++;
                $display("FAIL rand_resp[%0d]: addr=%0d we=%b got to=%b hit=%b data=%h, expected to=0 hit=%b data=%h",
                         n, a, we, o.timeout, o.hit, o.rdata, eh, ed);
            end
            checks++;
            if (o.lat != elat || o.hc !== CW'(m_hc) || o.mc !== CW'(m_mc)) begin
                errors++;
                $display("FAIL rand_lat_cnt[%0d]: got lat=%0d cnt=%0d/%0d, expected lat=%0d cnt=%0d/%0d",
                         n, o.lat, o.hc, o.mc, elat, m_hc, m_mc);
            end
            checks++;
            if ({o.rdy_before, o.en_first, o.mem_bad, o.en_in_resp, o.rdy_in_resp, o.rdy_after, o.rv_after}
                !== {1'b1, !(eh && !we), 5'b00010}) begin
                errors++;
                $display("FAIL rand_proto[%0d]: got %b, expected %b", n,
                         {o.rdy_before, o.en_first, o.mem_bad, o.en_in_resp, o.rdy_in_resp, o.rdy_after, o.rv_after},
                         {1'b1, !(eh && !we), 5'b00010});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(MEMN); i++) ref_mem[i] = DW'(i);
        model_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_miss();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
